// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect select: trap > branch > jump.
// Latency: combinational, zero cycles.
// Backpressure: none; the consumer decides whether to accept the redirect.
//
// Ports:
//   trap_valid/trap_vector, branch_taken/branch_target, jump_valid/jump_target : requests
//   redirect_valid/redirect_target : winning request, if any
module redirect_arb #(
    parameter int XLEN = 32
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target
);

    always_comb begin
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if (trap_valid) begin
            redirect_valid  = 1'b1;
            redirect_target = trap_vector;
        end else if (branch_taken) begin
            redirect_valid  = 1'b1;
            redirect_target = branch_target;
        end else if (jump_valid) begin
            redirect_valid  = 1'b1;
            redirect_target = jump_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: one outstanding imem request, one-entry output buffer to decode.
// Latency: first request 1 cycle after reset release; if_valid 1 cycle after imem_ack.
// Backpressure: holds the fetched instruction while if_ready is low; no new fetch until accepted.
//
// Ports:
//   clk, reset_n (async active-low)
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   if_valid/if_ready/if_instr/if_pc       : decode handshake
//   trap/branch/jump valid + target        : redirect requests
//   align_err                              : misaligned redirect pulse
// Optional feature macro: PC_ALIGN_CHECK_EN (force redirect targets to 4-byte alignment
// and pulse align_err); when undefined targets pass through and align_err is 0.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    output logic            align_err
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            capture;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            redir;
    logic [XLEN-1:0] redir_pc;

    redirect_arb #(.XLEN(XLEN)) u_arb (
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump_valid      (jump_valid),
        .jump_target     (jump_target),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    // Redirects are ignored in IDLE so nothing leaks in while coming out of reset.
    assign redir = redirect_valid && (state_q != IDLE);

`ifdef PC_ALIGN_CHECK_EN
    assign redir_pc = {redirect_target[XLEN-1:2], 2'b00};
`else
    assign redir_pc = redirect_target;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (redir) begin
                    // Without an ack the request is still outstanding and must be drained.
                    pc_d    = redir_pc;
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    capture = 1'b1;
                    pc_d    = pc_q + XLEN'(PC_INCR);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d    = redir_pc;
                    state_d = FETCH;
                end else if (if_ready) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redir)    pc_d    = redir_pc;
                if (imem_ack) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    // imem_addr only moves when (re)entering FETCH, which keeps it frozen through DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            imem_req <= (state_d == FETCH) || (state_d == DRAIN);
            if_valid <= (state_d == HOLD);
            if (state_d == FETCH) imem_addr <= pc_d;
            if (capture) begin
                if_instr <= imem_rdata;
                if_pc    <= pc_q;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) align_err <= 1'b0;
        else          align_err <= redir && (redirect_target[1:0] != 2'b00);
    end
`else
    assign align_err = 1'b0;
`endif

endmodule
